serial_operand_loader: RTL and testbench
========================================

SERIAL_OPERAND_LOADER -- requirements
Module: serial_operand_loader

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 Port: in_valid  input  1  operand pair on a_word/b_word is valid.
REQ-005 Port: in_ready  output  1  loader accepts the pair this cycle; transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-006 Port: a_word  input  WIDTH  operand A, parallel.
REQ-007 Port: b_word  input  WIDTH  operand B, parallel.
REQ-008 Port: a_bit  output  1  serial operand A bit to the serial adder, LSB first.
REQ-009 Port: b_bit  output  1  serial operand B bit to the serial adder, LSB first.
REQ-010 Port: bit_valid  output  1  a_bit/b_bit carry a live bit this cycle.
REQ-011 Port: first_bit  output  1  high with bit 0 of each pair; the adder's carry is cleared when this is high.
REQ-012 Port: last_bit  output  1  high with bit WIDTH-1 of each pair; the final carry_out is valid in this cycle.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-014 In IDLE: in_ready=1, bit_valid=0, a_bit=b_bit=first_bit=last_bit=0.
REQ-015 On transfer in IDLE: load shift registers, clear bit counter to 0, go to SHIFT; bit 0 appears on a_bit/b_bit in the next cycle (latency 1).
REQ-016 In SHIFT: bit_valid=1; a_bit/b_bit = LSB of the shift registers; the registers shift right by one each cycle and the counter increments.
REQ-017 first_bit SHALL equal (counter==0) in SHIFT; last_bit SHALL equal (counter==WIDTH-1) in SHIFT.
REQ-018 bit_valid SHALL stay high for exactly WIDTH consecutive cycles per accepted pair.
REQ-019 in_ready SHALL be high in the last_bit cycle; a transfer then reloads the registers, bit 0 of the new pair follows with no gap, and the FSM stays in SHIFT.
REQ-020 If there is no transfer in the last_bit cycle, the FSM SHALL return to IDLE.
REQ-021 in_ready SHALL be low in SHIFT except in the last_bit cycle; in_valid is ignored in those cycles, and a_word/b_word changes SHALL not affect bits in flight.
REQ-022 The counter width SHALL be $clog2(WIDTH), and it SHALL never exceed WIDTH-1.

Reset
REQ-023 With rst high: FSM to IDLE, counter and shift registers to 0, all outputs as in REQ-014; this applies immediately, mid-pair included, and the partial pair is discarded.
REQ-024 rst SHALL dominate in_valid in the same cycle: no transfer occurs.

Configuration
REQ-025 Macro: SERIAL_LOADER_DBUF_EN.
REQ-026 With SERIAL_LOADER_DBUF_EN defined: add a one-entry holding buffer; in_ready = buffer empty in any state; a pair accepted during SHIFT waits in the buffer and loads at the last_bit edge (gapless), emptying the buffer.
REQ-027 On the same edge as that load, a new pair SHALL be accepted into the emptied buffer.
REQ-028 Without SERIAL_LOADER_DBUF_EN: no buffer; behaviour is exactly REQ-013..REQ-022.
REQ-029 Reset SHALL empty the holding buffer.

Structure
REQ-030 Shared package serial_pkg SHALL hold the state enum (IDLE, SHIFT) and the default operand-width constant (4), shared with the serial adder and its testbenches.
REQ-031 No sub-module is required; when SERIAL_LOADER_DBUF_EN is defined, the holding buffer MAY be a sub-module named operand_hold_reg.

Verification
REQ-032 Single pair: A=4'b1011, B=4'b1101, one transfer -> (a,b) per cycle = (1,1),(1,0),(0,1),(1,1); first_bit on cycle 1; last_bit on cycle 4; then IDLE.
REQ-033 Back-to-back: second pair A=4'h3, B=4'h1 presented during last_bit -> no bit_valid gap; second pair bits (1,1),(1,0),(0,0),(0,0).
REQ-034 Busy rejection: in_valid held high through SHIFT -> in_ready=0 in cycles 1..3 only; exactly one transfer per pair.
REQ-035 Reset at cycle 2 of a pair -> next cycle bit_valid=0, in_ready=1, and no last_bit is seen.
REQ-036 With SERIAL_LOADER_DBUF_EN: three pairs streamed with in_valid always high -> 12 contiguous bit_valid cycles; in_ready low only while the buffer is full.
REQ-037 End to end with serial_adder_mealy, adder carry cleared on first_bit: 0xB + 0xD -> serial sum bits 0,0,0,1 and carry_out=1 on last_bit (0x18).

Source files
------------

// File: rtl/serial_pkg.sv
// ----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the bit-serial datapath (operand loader, serial
// adder and their benches).
//   state_t   : loader FSM states (IDLE, SHIFT)
//   DEF_WIDTH : default operand width in bits
// ----------------------------------------------------------------------------
package serial_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/serial_operand_loader.sv
// ----------------------------------------------------------------------------
// serial_operand_loader
// Accepts a parallel operand pair (a_word, b_word) with a valid/ready
// handshake and streams it LSB first, one bit of each operand per cycle,
// towards a serial adder. first_bit / last_bit frame each pair so the adder
// can clear its carry and capture its final carry_out.
//
// Parameters
//   WIDTH      operand width, 2..32
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   pair accepted when in_valid && in_ready at a rising edge
//   a_word     operand A (parallel)
//   b_word     operand B (parallel)
//   a_bit      serial operand A bit
//   b_bit      serial operand B bit
//   bit_valid  a_bit/b_bit are live
//   first_bit  bit 0 of a pair
//   last_bit   bit WIDTH-1 of a pair
//
// Build option
//   SERIAL_LOADER_DBUF_EN  adds a one-entry holding buffer so a pair can be
//                          accepted while the previous one is still shifting.
// ----------------------------------------------------------------------------
module serial_operand_loader
   import serial_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_word,
   input  logic [WIDTH-1:0] b_word,
   output logic             a_bit,
   output logic             b_bit,
   output logic             bit_valid,
   output logic             first_bit,
   output logic             last_bit
);

   localparam int            CW    = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic             at_last;   // SHIFT with counter at WIDTH-1
   logic             xfer;      // handshake completes this edge
   logic             load_go;   // shift registers take a new pair this edge
   logic [WIDTH-1:0] a_src, b_src;

   assign at_last = (state == SHIFT) && (cnt == LAST);
   assign xfer    = in_valid && in_ready;

`ifdef SERIAL_LOADER_DBUF_EN
   logic             hold_full;
   logic [WIDTH-1:0] hold_a, hold_b;

   // A buffered pair always goes ahead of a pair arriving on the same edge.
   assign load_go = ((state == IDLE) && xfer) || (at_last && (hold_full || xfer));
   assign a_src   = hold_full ? hold_a : a_word;
   assign b_src   = hold_full ? hold_b : b_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_full <= 1'b0;
         hold_a    <= '0;
         hold_b    <= '0;
      end else if (at_last && hold_full) begin
         // buffer drains into the shifter and may refill on the same edge
         hold_full <= xfer;
         if (xfer) begin
            hold_a <= a_word;
            hold_b <= b_word;
         end
      end else if ((state == SHIFT) && !at_last && xfer) begin
         hold_full <= 1'b1;
         hold_a    <= a_word;
         hold_b    <= b_word;
      end
   end
`else
   assign load_go = xfer;
   assign a_src   = a_word;
   assign b_src   = b_word;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state
   always_comb begin
      state_nxt = state;
      if (load_go)                          state_nxt = SHIFT;
      else if ((state == IDLE) || at_last)  state_nxt = IDLE;
   end

   // datapath: shift registers and bit counter
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         a_sr <= '0;
         b_sr <= '0;
      end else if (load_go) begin
         cnt  <= '0;
         a_sr <= a_src;
         b_sr <= b_src;
      end else if (state == SHIFT) begin
         cnt  <= at_last ? '0 : cnt + CW'(1);
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
      end
   end

   // outputs
   always_comb begin
      a_bit     = 1'b0;
      b_bit     = 1'b0;
      bit_valid = 1'b0;
      first_bit = 1'b0;
      last_bit  = 1'b0;
`ifdef SERIAL_LOADER_DBUF_EN
      in_ready  = !hold_full || at_last;
`else
      in_ready  = (state == IDLE) || at_last;
`endif
      if (state == SHIFT) begin
         bit_valid = 1'b1;
         a_bit     = a_sr[0];
         b_bit     = b_sr[0];
         first_bit = (cnt == '0);
         last_bit  = at_last;
      end
   end

endmodule

// File: tb/tb_serial_operand_loader.sv
// ----------------------------------------------------------------------------
// tb_serial_operand_loader
// Reference model: every accepted pair appends WIDTH expected bit records to a
// queue; each clock consumes one. in_ready is predicted from queue occupancy.
// A behavioural Mealy serial adder fed from the DUT outputs checks the
// end-to-end sum at each last bit.
// ----------------------------------------------------------------------------
module tb_serial_operand_loader;
   import serial_pkg::*;

   localparam int W = DEF_WIDTH;

   typedef struct {
      logic a;
      logic b;
      logic first;
      logic last;
      int   sum;
   } bit_rec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a_word = '0;
   logic [W-1:0] b_word = '0;
   logic         a_bit, b_bit, bit_valid, first_bit, last_bit;

   int errors = 0;
   int checks = 0;

   bit_rec_t q[$];

   // behavioural serial adder state
   logic         carry = 1'b0;
   logic [W-1:0] acc = '0;
   int           idx = 0;

   serial_operand_loader #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_word    (a_word),
      .b_word    (b_word),
      .a_bit     (a_bit),
      .b_bit     (b_bit),
      .bit_valid (bit_valid),
      .first_bit (first_bit),
      .last_bit  (last_bit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock: check outputs, drive inputs, advance the model
   task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic r);
      bit_rec_t e;
      logic     exp_ready, xfer, cin, s;
      @(negedge clk);
`ifdef SERIAL_LOADER_DBUF_EN
      exp_ready = (q.size() <= W + 1);
`else
      exp_ready = (q.size() <= 1);
`endif
      chk("in_ready", int'(in_ready), int'(exp_ready));
      if (q.size() > 0) begin
         e = q[0];
         chk("bit_valid", int'(bit_valid), 1);
         chk("a_bit", int'(a_bit), int'(e.a));
         chk("b_bit", int'(b_bit), int'(e.b));
         chk("first_bit", int'(first_bit), int'(e.first));
         chk("last_bit", int'(last_bit), int'(e.last));
      end else begin
         chk("idle_bit_valid", int'(bit_valid), 0);
         chk("idle_bits", int'({a_bit, b_bit, first_bit, last_bit}), 0);
      end
      // serial adder driven from the DUT
      if (bit_valid === 1'b1) begin
         if (first_bit === 1'b1) begin
            idx = 0;
            acc = '0;
         end
         cin = (first_bit === 1'b1) ? 1'b0 : carry;
         s   = a_bit ^ b_bit ^ cin;
         if (idx < W) acc[idx] = s;
         carry = (a_bit & b_bit) | (cin & (a_bit ^ b_bit));
         idx++;
         if (q.size() > 0 && e.last)
            chk("e2e_sum", int'({carry, acc}), e.sum);
      end
      in_valid = v;
      a_word   = a;
      b_word   = b;
      rst      = r;
      @(posedge clk);
      xfer = v && exp_ready && !r;
      if (r) q.delete();
      else begin
         if (q.size() > 0) void'(q.pop_front());
         if (xfer)
            for (int i = 0; i < W; i++)
               q.push_back('{a: a[i], b: b[i], first: (i == 0), last: (i == W - 1),
                             sum: int'(a) + int'(b)});
      end
   endtask

   initial begin
      // reset
      step(0, '0, '0, 1);
      step(1, 4'hF, 4'hF, 1);
      step(0, '0, '0, 0);
      // single pair 0xB / 0xD
      step(1, 4'b1011, 4'b1101, 0);
      for (int i = 0; i < 6; i++) step(0, '0, '0, 0);
      // back-to-back: second pair offered in the last-bit cycle
      step(1, 4'hB, 4'hD, 0);
      for (int i = 0; i < 3; i++) step(0, 4'h7, 4'h9, 0);
      step(1, 4'h3, 4'h1, 0);
      for (int i = 0; i < 6; i++) step(0, '0, '0, 0);
      // in_valid held high through shifting, words changing
      for (int i = 0; i < 14; i++) step(1, W'(i), W'(15 - i), 0);
      for (int i = 0; i < 10; i++) step(0, '0, '0, 0);
      // reset mid-pair (cycle 2)
      step(1, 4'hA, 4'h5, 0);
      step(0, '0, '0, 0);
      step(0, '0, '0, 1);
      for (int i = 0; i < 4; i++) step(0, '0, '0, 0);
      // boundary words
      step(1, 4'hF, 4'hF, 0);
      for (int i = 0; i < 3; i++) step(0, '0, '0, 0);
      step(1, 4'h0, 4'h0, 0);
      for (int i = 0; i < 5; i++) step(0, '0, '0, 0);
      // random traffic
      for (int i = 0; i < 3000; i++)
         step(($urandom % 4) != 0, W'($urandom), W'($urandom), ($urandom % 60) == 0);
      for (int i = 0; i < 12; i++) step(0, '0, '0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
